// File: rtl/square_root_sequencer_if.sv
// Sequencer <-> datapath/top bundle: start request, trial sign in; control word, status out.
// master = start source / datapath side, slave = sequencer side.
interface square_root_sequencer_if #(
  parameter int WIDTH = 4
);
  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;

  logic          start;
  logic          trial_sign;
  logic [5:0]    control;
  logic          valid;
  logic          busy;
  logic [CW-1:0] iteration;

  modport master (
    output start,
    output trial_sign,
    input  control,
    input  valid,
    input  busy,
    input  iteration
  );

  modport slave (
    input  start,
    input  trial_sign,
    output control,
    output valid,
    output busy,
    output iteration
  );
endinterface

// File: rtl/square_root_sequencer.sv
// Restoring square-root control FSM: start -> LOAD, N x (SHIFT,TRIAL,COMMIT), DONE pulses valid 3N+2 cycles later.
// start while busy is dropped unless SQRT_SEQ_START_QUEUE_EN adds a one-deep pending request.
module square_root_sequencer #(
  parameter int WIDTH = 4
) (
  input logic                    clock,
  input logic                    reset,
  square_root_sequencer_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    TRIAL  = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [5:0]    control;
  logic          valid;
  logic          busy;
  logic [CW-1:0] iteration;
  logic          relaunch;

`ifdef SQRT_SEQ_START_QUEUE_EN
  logic pending, pending_nxt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
`ifdef SQRT_SEQ_START_QUEUE_EN
      pending <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
`ifdef SQRT_SEQ_START_QUEUE_EN
      pending <= pending_nxt;
`endif
    end
  end

  // A request arriving in DONE (or one queued earlier) chains straight into LOAD.
`ifdef SQRT_SEQ_START_QUEUE_EN
  assign relaunch = pending | bus.start;
`else
  assign relaunch = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    control   = 6'b000000;
    valid     = 1'b0;
    busy      = 1'b1;
    iteration = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_nxt = LOAD;
      end
      LOAD: begin
        control   = 6'b000011;
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        control   = 6'b000100;
        iteration = cnt;
        state_nxt = TRIAL;
      end
      TRIAL: begin
        control   = 6'b001000;
        iteration = cnt;
        state_nxt = COMMIT;
      end
      COMMIT: begin
        // Digit accept is the only Mealy output; a 0 tells the datapath to restore.
        control[4] = ~bus.trial_sign;
        iteration  = cnt;
        if (cnt == LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + CW'(1);
          state_nxt = SHIFT;
        end
      end
      DONE: begin
        control   = 6'b100000;
        valid     = 1'b1;
        state_nxt = relaunch ? LOAD : IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef SQRT_SEQ_START_QUEUE_EN
  always_comb begin
    pending_nxt = pending;
    if (state == DONE)      pending_nxt = 1'b0;
    else if (busy)          pending_nxt = pending | bus.start;
  end
`endif

  assign bus.control   = control;
  assign bus.valid     = valid;
  assign bus.busy      = busy;
  assign bus.iteration = iteration;
endmodule

// File: tb/tb_square_root_sequencer.sv
// Scoreboard bench: stimulus schedules expected control/status per cycle from an integer sqrt model;
// a negedge monitor compares every cycle and pops expected results on valid.
module tb_square_root_sequencer;
  localparam int W = 4;
  localparam int N = W / 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  square_root_sequencer_if #(.WIDTH(W)) bus();

  square_root_sequencer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int root;
    int cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         load_q[$];
  logic [5:0] exp_ctrl[int];
  int         exp_iter[int];
  bit         exp_busy[int];
  bit         exp_valid[int];
  int         done_cyc = -1;
  bit         pending = 1'b0;

  bit force_en  = 1'b0;
  bit force_val = 1'b0;

  // Behavioural restoring datapath driven only by the control word.
  int dp_rad = 0, dp_rem = 0, dp_root = 0, dp_trial = 0;
  assign bus.trial_sign = force_en ? force_val : (dp_trial < 0);

  always @(posedge clock) begin : datapath
    int a;
    if (bus.control[0] === 1'b1) begin
      a = 0;
      if (load_q.size() > 0) a = load_q.pop_front();
      dp_rad <= a;
    end
    if (bus.control[1] === 1'b1) begin
      dp_rem  <= 0;
      dp_root <= 0;
    end
    if (bus.control[2] === 1'b1) begin
      dp_rem <= (dp_rem * 4) + ((dp_rad >> (W - 2)) & 3);
      dp_rad <= (dp_rad << 2) & ((1 << W) - 1);
    end
    if (bus.control[3] === 1'b1) dp_trial <= dp_rem - (dp_root * 4 + 1);
    if (bus.busy === 1'b1 && bus.control === 6'h10) begin
      dp_rem  <= dp_trial;
      dp_root <= dp_root * 2 + 1;
    end else if (bus.busy === 1'b1 && bus.control === 6'h00) begin
      dp_root <= dp_root * 2;
    end
  end

  function automatic int isqrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  task automatic chk(input string nm, input int c, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, got, want);
    end
  endtask

  // Start accepted in cycle k: LOAD at k+1, iteration i at k+2+3i.., DONE at k+2+3N.
  task automatic sched(input int k, input int r, input int alpha);
    exp_t e;
    int   b;
    exp_ctrl[k + 1] = 6'h03; exp_busy[k + 1] = 1'b1; exp_iter[k + 1] = 0;
    for (int i = 0; i < N; i++) begin
      b = k + 2 + 3 * i;
      exp_ctrl[b]     = 6'h04;
      exp_ctrl[b + 1] = 6'h08;
      exp_ctrl[b + 2] = ((r >> (N - 1 - i)) & 1) ? 6'h10 : 6'h00;
      for (int j = 0; j < 3; j++) begin
        exp_busy[b + j] = 1'b1;
        exp_iter[b + j] = i;
      end
    end
    b = k + 2 + 3 * N;
    exp_ctrl[b] = 6'h20; exp_busy[b] = 1'b1; exp_valid[b] = 1'b1; exp_iter[b] = 0;
    e.root = r;
    e.cyc  = b;
    sb_q.push_back(e);
    load_q.push_back(alpha);
    done_cyc = b;
  endtask

  task automatic model(input int k, input bit s, input bit r, input int alpha, input int rovr);
    int root;
    root = (rovr >= 0) ? rovr : isqrt(alpha);
    if (r) begin
      for (int j = k + 1; j <= k + 3 * N + 3; j++) begin
        exp_ctrl.delete(j); exp_busy.delete(j); exp_iter.delete(j); exp_valid.delete(j);
      end
      for (int q = sb_q.size() - 1; q >= 0; q--)
        if (sb_q[q].cyc > k) sb_q.delete(q);
      pending  = 1'b0;
      done_cyc = k;
    end else if (k > done_cyc) begin
      if (s) sched(k, root, alpha);
    end else begin
`ifdef SQRT_SEQ_START_QUEUE_EN
      if (s) pending = 1'b1;
      if (k == done_cyc && pending) begin
        pending = 1'b0;
        sched(k, root, alpha);
      end
`endif
    end
  endtask

  task automatic step(input bit s, input bit r, input int alpha, input int rovr);
    bus.start = s;
    reset     = r;
    model(cyc, s, r, alpha, rovr);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin : monitor
    int   c;
    exp_t e;
    c = cyc;
    if (c >= 1) begin
      chk("control",   c, int'(bus.control),   exp_ctrl.exists(c)  ? int'(exp_ctrl[c])  : 0);
      chk("busy",      c, int'(bus.busy),      exp_busy.exists(c)  ? int'(exp_busy[c])  : 0);
      chk("valid",     c, int'(bus.valid),     exp_valid.exists(c) ? int'(exp_valid[c]) : 0);
      chk("iteration", c, int'(bus.iteration), exp_iter.exists(c)  ? exp_iter[c]        : 0);
      if (bus.valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_nonempty_on_valid", c, sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          chk("valid_cycle", c, c, e.cyc);
          chk("root", c, dp_root, e.root);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    step(0, 1, 0, -1);
    step(0, 1, 0, -1);
    repeat (10) step(0, 0, 0, -1);

    step(1, 0, 9, -1);
    repeat (12) step(0, 0, 0, -1);

    // Forced signs 0 then 1: digits accept, reject -> root 2'b10.
    force_en = 1'b1;
    for (int j = 0; j < 12; j++) begin
      force_val = (j >= 5);
      step(j == 0, 0, 2, 2);
    end
    force_en = 1'b0;

    for (int j = 0; j < 28; j++) step(j == 0, j == 6, $urandom_range(0, 15), -1);

    for (int j = 0; j < 25; j++) step(j == 0 || j == 3, 0, $urandom_range(0, 15), -1);

    for (int j = 0; j < 30; j++) step(1, 0, $urandom_range(0, 15), -1);
    repeat (12) step(0, 0, 0, -1);

    repeat (300) step($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 15), -1);
    repeat (15) step(0, 0, 0, -1);

    chk("scoreboard_drained", cyc, sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
